// File: rtl/sum_sequencer.sv
// sum_sequencer
//
// Purpose:
//   Sequencing controller for an N-bit adder datapath driven by a single
//   pushbutton. Each accepted press steps the user through: capture operand A
//   from the switches, capture operand B, compute (one cycle), show the result.
//   With chain set, the press that leaves SHOW feeds the N-bit sum back as the
//   next operand A so running totals can be accumulated.
//
// Ports:
//   clk           in   1     system clock
//   rst           in   1     asynchronous active-high reset
//   data_in       in   N     operand value from the switches (sampled on press)
//   step_n        in   1     raw pushbutton, active-low, asynchronous, bouncy
//   chain         in   1     SHOW exit select: 0 -> LOAD_A, 1 -> LOAD_B with A=sum
//   add_a         out  N     external adder operand A (mirrors op_a)
//   add_b         out  N     external adder operand B (mirrors op_b)
//   add_s         in   N     external adder sum (combinational from add_a/add_b)
//   add_cout      in   1     external adder carry-out
//   op_a          out  N     registered operand A
//   op_b          out  N     registered operand B
//   result        out  N+1   registered {carry, sum}
//   result_valid  out  1     high only in SHOW
//   state         out  2     LOAD_A=0, LOAD_B=1, CALC=2, SHOW=3
//
// Parameters:
//   N                operand / adder width
//   DEBOUNCE_CYCLES  consecutive stable cycles to accept a key level change (>= 2)

module sum_sequencer #(
  parameter int unsigned N               = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] data_in,
  input  logic         step_n,
  input  logic         chain,
  output logic [N-1:0] add_a,
  output logic [N-1:0] add_b,
  input  logic [N-1:0] add_s,
  input  logic         add_cout,
  output logic [N-1:0] op_a,
  output logic [N-1:0] op_b,
  output logic [N:0]   result,
  output logic         result_valid,
  output logic [1:0]   state
);

  // FSM encoding is externally visible on the state port, so it is fixed.
  localparam logic [1:0] StLoadA = 2'd0;
  localparam logic [1:0] StLoadB = 2'd1;
  localparam logic [1:0] StCalc  = 2'd2;
  localparam logic [1:0] StShow  = 2'd3;

  // Counter only needs to reach DEBOUNCE_CYCLES-1.
  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Input conditioning: synchronizer, debouncer, press edge detect
  // ---------------------------------------------------------------------------

  logic            r_sync_1;
  logic            r_sync_2;
  logic            r_key_db;
  logic            r_key_db_prev;
  logic [CntW-1:0] r_db_cnt;
  logic            w_press;

  // Both stages reset to 1 so a reset never looks like a key going down.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync_1 <= 1'b1;
      r_sync_2 <= 1'b1;
    end else begin
      r_sync_1 <= step_n;
      r_sync_2 <= r_sync_1;
    end
  end

  // Any cycle where the sample agrees with the debounced level restarts the
  // count, so bounces shorter than DEBOUNCE_CYCLES are never accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_db_cnt <= '0;
      r_key_db <= 1'b1;
    end else if (r_sync_2 != r_key_db) begin
      if (r_db_cnt == CntLast) begin
        r_db_cnt <= '0;
        r_key_db <= r_sync_2;
      end else begin
        r_db_cnt <= r_db_cnt + CntW'(1);
      end
    end else begin
      r_db_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key_db_prev <= 1'b1;
    end else begin
      r_key_db_prev <= r_key_db;
    end
  end

  // One-cycle pulse on the debounced 1->0 edge only; release is not an event.
  assign w_press = r_key_db_prev & ~r_key_db;

  // ---------------------------------------------------------------------------
  // Sequencer FSM and datapath registers
  // ---------------------------------------------------------------------------

  logic [1:0]   r_state;
  logic [N-1:0] r_op_a;
  logic [N-1:0] r_op_b;
  logic [N:0]   r_result;

  logic [1:0]   w_state_next;
  logic [N-1:0] w_op_a_next;
  logic [N-1:0] w_op_b_next;
  logic [N:0]   w_result_next;

  always_comb begin
    w_state_next  = r_state;
    w_op_a_next   = r_op_a;
    w_op_b_next   = r_op_b;
    w_result_next = r_result;

    unique case (r_state)
      StLoadA: begin
        if (w_press) begin
          w_op_a_next  = data_in;
          w_op_b_next  = '0;
          w_state_next = StLoadB;
        end
      end

      StLoadB: begin
        if (w_press) begin
          w_op_b_next  = data_in;
          w_state_next = StCalc;
        end
      end

      // Operands have been stable since the LOAD_B press edge, so the
      // external adder output is settled here. A press in this cycle is lost.
      StCalc: begin
        w_result_next = {add_cout, add_s};
        w_state_next  = StShow;
      end

      StShow: begin
        if (w_press) begin
          w_op_b_next   = '0;
          w_result_next = '0;
          if (chain) begin
            // Running total: carry is dropped, it was only visible in SHOW.
            w_op_a_next  = r_result[N-1:0];
            w_state_next = StLoadB;
          end else begin
            w_op_a_next  = '0;
            w_state_next = StLoadA;
          end
        end
      end

      default: begin
        w_state_next = StLoadA;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StLoadA;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_result <= '0;
    end else begin
      r_state  <= w_state_next;
      r_op_a   <= w_op_a_next;
      r_op_b   <= w_op_b_next;
      r_result <= w_result_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------

  assign add_a        = r_op_a;
  assign add_b        = r_op_b;
  assign op_a         = r_op_a;
  assign op_b         = r_op_b;
  assign result       = r_result;
  assign result_valid = (r_state == StShow);
  assign state        = r_state;

  // CALC never lingers: it always hands over to SHOW on the next edge.
  a_calc_one_cycle : assert property (
    @(posedge clk) disable iff (rst) (r_state == StCalc) |=> (r_state == StShow)
  );

endmodule

// File: doc/sum_sequencer.md
# sum_sequencer

Sequencing controller for the board's N-bit adder datapath. One debounced pushbutton steps the user through operand entry: capture A from the switches, capture B, compute, show. The block drives the adder's operands, registers the sum and carry, and presents operands, result and state to the seven-segment display decoders. Chain mode feeds the result back as the next A for running totals.

## Interface

- N, default 4: operand width in bits; adder width.
- DEBOUNCE_CYCLES, default 500000: consecutive stable cycles needed to accept a key level change (10 ms at 50 MHz); minimum 2.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- data_in  in  N  operand value from the switches; sampled only on an accepted press.
- step_n  in  1  raw pushbutton, active-low, asynchronous to clk, bouncy.
- chain  in  1  level from a switch; selects the exit from SHOW.
- add_a  out  N  adder operand A; always equals op_a.
- add_b  out  N  adder operand B; always equals op_b.
- add_s  in  N  adder sum (combinational from add_a/add_b).
- add_cout  in  1  adder carry-out.
- op_a  out  N  registered operand A.
- op_b  out  N  registered operand B.
- result  out  N+1  registered {carry, sum}.
- result_valid  out  1  high only in SHOW.
- state  out  2  FSM encoding: LOAD_A=0, LOAD_B=1, CALC=2, SHOW=3.

## Operation

- Input conditioning:
  - step_n passes a 2-flop synchronizer; both flops reset to 1.
  - Debounced level `key_db` resets to 1 (released).
  - Counter: increments each cycle the synchronized sample differs from `key_db`. Clears to 0 when they match, or when it reaches DEBOUNCE_CYCLES−1. In that terminal cycle `key_db` takes the sample value.
  - `press` is a one-cycle pulse on a `key_db` 1→0 transition. Release generates no event.
- FSM. All transitions occur only in the cycle `press`=1, except CALC.
  - LOAD_A: on press, op_a←data_in, op_b←0; go to LOAD_B.
  - LOAD_B: on press, op_b←data_in; go to CALC.
  - CALC: unconditional, one cycle. result←{add_cout, add_s}; go to SHOW. A press arriving while in CALC is ignored.
  - SHOW: result_valid=1. On press with chain=0: op_a←0, op_b←0, result←0, go to LOAD_A. On press with chain=1: op_a←result[N−1:0] (carry discarded), op_b←0, result←0, go to LOAD_B.
- Arithmetic: plain unsigned. result is N+1 bits, so no overflow is possible in a single add. Chain mode truncates to N bits; the carry is visible in result[N] during SHOW before the press.
- chain and data_in are sampled only in the press cycle. Changes at other times have no effect.
- Reset, asynchronous at any time including mid-debounce or in CALC:
  - state=LOAD_A; op_a, op_b and result = 0; result_valid=0.
  - Debounce counter = 0; synchronizer and `key_db` = 1; `press`=0.
  - A key held through reset deassertion registers one press after the full debounce time.

## Timing

- Press latency: a step_n falling edge that then stays stable yields a `press` pulse in cycle 2 + DEBOUNCE_CYCLES after the first synchronizer capture (±1 for metastability resolution). The FSM updates at the following edge.
- Bounce shorter than DEBOUNCE_CYCLES cycles restarts the count and produces no event.
- One physical press yields exactly one step, regardless of hold time.
- CALC→SHOW is a fixed 1 cycle after the LOAD_B press edge. result is valid and result_valid asserts on the edge entering SHOW.
- The adder path is combinational, registered only in CALC. op_a and op_b are stable for at least 1 cycle before the CALC edge.

## Test plan

Run with N=4 and DEBOUNCE_CYCLES=4.

- Reset check: assert rst mid-count after step_n has been low for 2 cycles, then release and return step_n high -> state=0, op_a=0, op_b=0, result=0, result_valid=0; no press generated.
- Basic add: press with data_in=5, press with data_in=9 -> op_a=5, op_b=9; 1 cycle after the second press is accepted, state=3, result=5'b01110 (14), result_valid=1.
- Carry: A=15, B=15 -> result=5'b11110 (30). In SHOW, press with chain=0 -> state=0 and all registers 0.
- Chain: A=12, B=7 -> result=19. Press with chain=1 -> op_a=3, op_b=0, state=1. Press with data_in=2 -> result=5.
- Bounce rejection: toggle step_n low/high every 2 cycles for 20 cycles, then hold low 10 cycles -> exactly one press and one state advance. Holding 100 more cycles gives no further advance.
- Ignored inputs: change data_in and chain every cycle between presses, and press during CALC -> only press-cycle values are captured. CALC always lasts exactly 1 cycle.
